test_data_check: RTL and testbench
==================================

TEST_DATA_CHECK -- requirements
Module: test_data_check

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of byte_count and err_count.
REQ-002 SHALL have parameter LOSS_THRESH, default 3, meaning the consecutive LOCKED mismatches that cause loss of lock (range 1..7).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port RxD_data_ready, input, 1 bit: one-cycle strobe meaning RxD_data holds a received byte.
REQ-006 SHALL have port RxD_data, input, 8 bits: received byte, valid only while RxD_data_ready=1.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of counters and lock.
REQ-008 SHALL have port locked, output, 1 bit: high in state LOCKED.
REQ-009 SHALL have port match_pulse, output, 1 bit: one-cycle pulse when a LOCKED byte matches the expected byte.
REQ-010 SHALL have port err_pulse, output, 1 bit: one-cycle pulse when a LOCKED byte mismatches the expected byte.
REQ-011 SHALL have port byte_count, output, CNT_W bits: bytes checked while LOCKED.
REQ-012 SHALL have port err_count, output, CNT_W bits: mismatches while LOCKED.
REQ-013 SHALL have port exp_idx, output, 3 bits: index of the next expected pattern byte.

Function
REQ-014 SHALL use the fixed cyclic pattern P[0..4] = 0x68, 0x65, 0x6C, 0x6C, 0x6F ("hello").
REQ-015 SHALL process a byte only on cycles where RxD_data_ready=1; all other cycles hold state, and a ready high for N cycles counts as N bytes.
REQ-016 SHALL register all outputs, with results visible on the clock edge following the RxD_data_ready cycle (latency 1).
REQ-017 SHALL advance exp_idx 0,1,2,3,4 and wrap from 4 to 0.
REQ-018 SHALL implement the states HUNT, ALIGN and LOCKED.
REQ-019 HUNT: a byte of 0x68 SHALL move to ALIGN with exp_idx=1; any other byte SHALL stay in HUNT with exp_idx=0.
REQ-020 ALIGN, byte == P[exp_idx]: exp_idx SHALL advance; if exp_idx was 4, the state SHALL move to LOCKED with exp_idx=0.
REQ-021 ALIGN, byte != P[exp_idx]: if the byte is 0x68, the state SHALL stay in ALIGN with exp_idx=1; otherwise it SHALL return to HUNT with exp_idx=0.
REQ-022 LOCKED: every byte SHALL increment byte_count and advance exp_idx, whether or not it matches.
REQ-023 LOCKED match: match_pulse SHALL assert and the consecutive-error count SHALL be zeroed.
REQ-024 LOCKED mismatch: err_pulse SHALL assert, err_count SHALL increment and the consecutive-error count SHALL increment.
REQ-025 When the consecutive-error count reaches LOSS_THRESH, the block SHALL move to HUNT with exp_idx=0; the mismatching byte SHALL still be counted in err_count and byte_count.
REQ-026 byte_count and err_count SHALL saturate at all-ones and not wrap.
REQ-027 match_pulse and err_pulse SHALL never be high in the same cycle, and SHALL be low outside LOCKED.
REQ-028 clear=1 SHALL, on the next edge, zero the counters, exp_idx and the consecutive-error count, enter HUNT and deassert the pulses.
REQ-029 When clear and RxD_data_ready are high in the same cycle, clear SHALL win and the byte SHALL be dropped.
REQ-030 Counters SHALL persist across loss of lock; only clear or reset SHALL zero them.

Reset
REQ-031 reset_n=0 SHALL immediately force HUNT, locked=0, match_pulse=0, err_pulse=0, byte_count=0, err_count=0, exp_idx=0 and a consecutive-error count of 0.
REQ-032 Reset asserted mid-pattern SHALL discard any alignment, and after deassertion the block SHALL restart from HUNT.
REQ-033 Bytes strobed during reset SHALL be ignored.

Verification
REQ-034 Send "hello" then "hello": locked rises after the 5th byte, and after the 10th byte byte_count=5, err_count=0, with 5 match_pulses.
REQ-035 Send 0x00, 0x68, 0x68, 0x65, 0x6C, 0x6C, 0x6F: stays HUNT, then ALIGN restarts on the repeated 'h', and the block locks after the last byte.
REQ-036 Once locked, send 0x68, 0x65, 0x00, 0x6C, 0x6F: err_count=1, byte_count=5, locked stays 1, and exp_idx=0.
REQ-037 Once locked, send 3 consecutive 0x00 bytes: err_count=3, locked=0 after the 3rd byte, and the state is HUNT.
REQ-038 With CNT_W=4, once locked, send 20 bytes of 0x00 with LOSS_THRESH=7 and relocks between them: err_count holds at 15 and never wraps.
REQ-039 Assert clear together with RxD_data_ready while locked: counters=0, locked=0, and the byte is not counted; then assert reset_n=0 mid-ALIGN: exp_idx=0 immediately.

Source files
------------

// File: rtl/test_data_check.sv
// Byte-stream checker that hunts for, aligns to and then tracks the cyclic "hello" pattern,
// counting matched and mismatched bytes while locked and dropping lock after repeated errors.
module test_data_check #(
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RxD_data_ready,
  input  logic [7:0]       RxD_data,
  input  logic             clear,
  output logic             locked,
  output logic             match_pulse,
  output logic             err_pulse,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       exp_idx
);

  typedef enum logic [1:0] {HUNT = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [2:0]       THRESH = 3'(LOSS_THRESH);
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [2:0]       idx_nxt, cons, cons_nxt;
  logic             match_nxt, err_nxt, byte_hit;
  logic [CNT_W-1:0] bc_nxt, ec_nxt;

  function automatic logic [7:0] pat(input logic [2:0] idx);
    case (idx)
      3'd0:    pat = 8'h68;
      3'd1:    pat = 8'h65;
      3'd2:    pat = 8'h6C;
      3'd3:    pat = 8'h6C;
      3'd4:    pat = 8'h6F;
      default: pat = 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] idx_inc(input logic [2:0] idx);
    idx_inc = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + ONE;
  endfunction

  assign byte_hit = (RxD_data == pat(exp_idx));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      exp_idx     <= 3'd0;
      cons        <= 3'd0;
      locked      <= 1'b0;
      match_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      byte_count  <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      exp_idx     <= idx_nxt;
      cons        <= cons_nxt;
      locked      <= (state_nxt == LOCKED);
      match_pulse <= match_nxt;
      err_pulse   <= err_nxt;
      byte_count  <= bc_nxt;
      err_count   <= ec_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = exp_idx;
    cons_nxt  = cons;
    if (clear) begin
      state_nxt = HUNT;
      idx_nxt   = 3'd0;
      cons_nxt  = 3'd0;
    end else if (RxD_data_ready) begin
      case (state)
        HUNT: begin
          if (RxD_data == 8'h68) begin
            state_nxt = ALIGN;
            idx_nxt   = 3'd1;
          end
        end
        ALIGN: begin
          if (byte_hit) begin
            idx_nxt = idx_inc(exp_idx);
            if (exp_idx == 3'd4) state_nxt = LOCKED;
          end else if (RxD_data == 8'h68) begin
            idx_nxt = 3'd1;
          end else begin
            state_nxt = HUNT;
            idx_nxt   = 3'd0;
          end
        end
        LOCKED: begin
          idx_nxt = idx_inc(exp_idx);
          if (byte_hit) begin
            cons_nxt = 3'd0;
          end else if (cons + 3'd1 == THRESH) begin
            // Lock lost: this byte is still counted by the output logic below
            state_nxt = HUNT;
            idx_nxt   = 3'd0;
            cons_nxt  = 3'd0;
          end else begin
            cons_nxt = cons + 3'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          idx_nxt   = 3'd0;
          cons_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    match_nxt = 1'b0;
    err_nxt   = 1'b0;
    bc_nxt    = byte_count;
    ec_nxt    = err_count;
    if (clear) begin
      bc_nxt = '0;
      ec_nxt = '0;
    end else if (RxD_data_ready && state == LOCKED) begin
      bc_nxt = sat_inc(byte_count);
      if (byte_hit) begin
        match_nxt = 1'b1;
      end else begin
        err_nxt = 1'b1;
        ec_nxt  = sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_test_data_check.sv
// Scoreboard bench for test_data_check: two instances (default, and CNT_W=4/LOSS_THRESH=7)
// share stimulus; a behavioural model queues expected outputs checked one cycle later.
module tb_test_data_check;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       RxD_data_ready;
  logic [7:0] RxD_data;
  logic       clear;

  logic        lk0, mp0, ep0, lk1, mp1, ep1;
  logic [15:0] bc0, ec0;
  logic [3:0]  bc1, ec1;
  logic [2:0]  idx0, idx1;

  typedef struct {
    logic        lk, mp, ep;
    logic [15:0] bc, ec;
    logic [2:0]  idx;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int n_cmp = 0;
  int n_err = 0;
  int mp_cnt = 0;

  logic [7:0] pat [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  int cmax [2] = '{65535, 15};
  int thr  [2] = '{3, 7};
  int m_st [2], m_idx [2], m_cons [2], m_bc [2], m_ec [2];
  bit m_mp [2], m_ep [2];

  test_data_check u_dut0 (
    .clk(clk), .reset_n(reset_n), .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
    .clear(clear), .locked(lk0), .match_pulse(mp0), .err_pulse(ep0),
    .byte_count(bc0), .err_count(ec0), .exp_idx(idx0)
  );

  test_data_check #(.CNT_W(4), .LOSS_THRESH(7)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
    .clear(clear), .locked(lk1), .match_pulse(mp1), .err_pulse(ep1),
    .byte_count(bc1), .err_count(ec1), .exp_idx(idx1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_idx[i] = 0; m_cons[i] = 0; m_bc[i] = 0; m_ec[i] = 0;
      m_mp[i] = 0; m_ep[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit rdy, input logic [7:0] d, input bit clr);
    bit hit;
    m_mp[i] = 0;
    m_ep[i] = 0;
    if (clr) begin
      m_st[i] = 0; m_idx[i] = 0; m_cons[i] = 0; m_bc[i] = 0; m_ec[i] = 0;
    end else if (rdy) begin
      hit = (d == pat[m_idx[i]]);
      case (m_st[i])
        0: if (d == 8'h68) begin m_st[i] = 1; m_idx[i] = 1; end
        1: begin
          if (hit) begin
            if (m_idx[i] == 4) begin m_st[i] = 2; m_idx[i] = 0; end
            else m_idx[i] = m_idx[i] + 1;
          end else if (d == 8'h68) m_idx[i] = 1;
          else begin m_st[i] = 0; m_idx[i] = 0; end
        end
        default: begin
          if (m_bc[i] < cmax[i]) m_bc[i]++;
          m_idx[i] = (m_idx[i] + 1) % 5;
          if (hit) begin
            m_mp[i] = 1; m_cons[i] = 0;
          end else begin
            m_ep[i] = 1;
            if (m_ec[i] < cmax[i]) m_ec[i]++;
            m_cons[i]++;
            if (m_cons[i] == thr[i]) begin m_st[i] = 0; m_idx[i] = 0; m_cons[i] = 0; end
          end
        end
      endcase
    end
  endtask

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.lk  = (m_st[i] == 2);
    e.mp  = m_mp[i];
    e.ep  = m_ep[i];
    e.bc  = 16'(m_bc[i]);
    e.ec  = 16'(m_ec[i]);
    e.idx = 3'(m_idx[i]);
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    if (sb0.size() == 0 || sb1.size() == 0) begin
      check_val("sb_empty", 32'(sb0.size() + sb1.size()), 32'd2);
      return;
    end
    e = sb0.pop_front();
    check_val("d0_locked", 32'(lk0), 32'(e.lk));
    check_val("d0_match", 32'(mp0), 32'(e.mp));
    check_val("d0_err", 32'(ep0), 32'(e.ep));
    check_val("d0_bcnt", 32'(bc0), 32'(e.bc));
    check_val("d0_ecnt", 32'(ec0), 32'(e.ec));
    check_val("d0_idx", 32'(idx0), 32'(e.idx));
    check_val("d0_pulse_excl", 32'(mp0 & ep0), 32'd0);
    if (mp0) mp_cnt++;
    e = sb1.pop_front();
    check_val("d1_locked", 32'(lk1), 32'(e.lk));
    check_val("d1_match", 32'(mp1), 32'(e.mp));
    check_val("d1_err", 32'(ep1), 32'(e.ep));
    check_val("d1_bcnt", 32'(bc1), 32'(e.bc));
    check_val("d1_ecnt", 32'(ec1), 32'(e.ec));
    check_val("d1_idx", 32'(idx1), 32'(e.idx));
  endtask

  task automatic drive(input bit rdy, input logic [7:0] d, input bit clr);
    @(negedge clk);
    RxD_data_ready = rdy;
    RxD_data       = d;
    clear          = clr;
    model_step(0, rdy, d, clr);
    model_step(1, rdy, d, clr);
    sb0.push_back(model_out(0));
    sb1.push_back(model_out(1));
    @(posedge clk);
    #1;
    RxD_data_ready = 1'b0;
    clear          = 1'b0;
    compare_outputs();
  endtask

  task automatic send_hello();
    for (int k = 0; k < 5; k++) drive(1'b1, pat[k], 1'b0);
  endtask

  task automatic send_zeros(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] s35 [7] = '{8'h00, 8'h68, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    logic [7:0] s36 [5] = '{8'h68, 8'h65, 8'h00, 8'h6C, 8'h6F};
    reset_n = 1'b0; RxD_data_ready = 1'b0; RxD_data = 8'h00; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_locked", 32'(lk0), 32'd0);
    check_val("rst_bcnt", 32'(bc0), 32'd0);
    check_val("rst_ecnt", 32'(ec0), 32'd0);
    check_val("rst_idx", 32'(idx0), 32'd0);
    check_val("rst_pulses", 32'({mp0, ep0, mp1, ep1}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // hello hello
    drive(1'b0, 8'h00, 1'b1);
    mp_cnt = 0;
    for (int k = 0; k < 4; k++) drive(1'b1, pat[k], 1'b0);
    check_val("h4_not_locked", 32'(lk0), 32'd0);
    drive(1'b1, pat[4], 1'b0);
    check_val("h5_locked", 32'(lk0), 32'd1);
    send_hello();
    check_val("hh_bcnt", 32'(bc0), 32'd5);
    check_val("hh_ecnt", 32'(ec0), 32'd0);
    check_val("hh_matches", 32'(mp_cnt), 32'd5);

    // HUNT, then ALIGN restart on repeated 'h'
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, s35[k], 1'b0);
      if (k == 0) check_val("s35_hunt_idx", 32'(idx0), 32'd0);
      if (k == 2) check_val("s35_realign_idx", 32'(idx0), 32'd1);
    end
    check_val("s35_locked", 32'(lk0), 32'd1);

    // single error while locked
    for (int k = 0; k < 5; k++) drive(1'b1, s36[k], 1'b0);
    check_val("s36_ecnt", 32'(ec0), 32'd1);
    check_val("s36_bcnt", 32'(bc0), 32'd5);
    check_val("s36_locked", 32'(lk0), 32'd1);
    check_val("s36_idx", 32'(idx0), 32'd0);

    // loss of lock after three errors, idle cycles hold state
    drive(1'b0, 8'h00, 1'b1);
    send_hello();
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h68, 1'b0);
    send_zeros(2);
    check_val("s37_still_locked", 32'(lk0), 32'd1);
    send_zeros(1);
    check_val("s37_ecnt", 32'(ec0), 32'd3);
    check_val("s37_lost", 32'(lk0), 32'd0);
    check_val("s37_idx", 32'(idx0), 32'd0);

    // saturation on the narrow instance
    drive(1'b0, 8'h00, 1'b1);
    send_hello();
    send_zeros(7);
    check_val("s38_d1_lost", 32'(lk1), 32'd0);
    check_val("s38_d1_ecnt7", 32'(ec1), 32'd7);
    send_hello();
    send_zeros(7);
    send_hello();
    send_zeros(6);
    check_val("s38_d1_ecnt_sat", 32'(ec1), 32'd15);
    check_val("s38_d1_bcnt_sat", 32'(bc1), 32'd15);
    check_val("s38_d0_counts_persist", 32'(ec0), 32'd9);

    // clear wins over a strobed byte
    drive(1'b0, 8'h00, 1'b1);
    send_hello();
    drive(1'b1, 8'h68, 1'b1);
    check_val("clr_bcnt", 32'(bc0), 32'd0);
    check_val("clr_locked", 32'(lk0), 32'd0);
    check_val("clr_byte_dropped", 32'(idx0), 32'd0);

    // asynchronous reset mid-ALIGN, bytes during reset ignored
    drive(1'b1, 8'h68, 1'b0);
    drive(1'b1, 8'h65, 1'b0);
    check_val("align_idx", 32'(idx0), 32'd2);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("async_rst_idx", 32'(idx0), 32'd0);
    check_val("async_rst_idx1", 32'(idx1), 32'd0);
    RxD_data_ready = 1'b1;
    RxD_data       = 8'h68;
    @(posedge clk);
    #1;
    check_val("rst_byte_ignored", 32'(idx0), 32'd0);
    @(negedge clk);
    RxD_data_ready = 1'b0;
    reset_n = 1'b1;
    drive(1'b1, 8'h65, 1'b0);
    check_val("post_rst_hunt", 32'(idx0), 32'd0);
    send_hello();
    check_val("post_rst_relock", 32'(lk0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
